// File: rtl/rsign_pkg.sv
// rsign_pkg: state type and width helpers shared by rsign_stream and rsign_lane
package rsign_pkg;
  typedef enum logic {S_LOAD = 1'b0, S_RUN = 1'b1} state_t;
  function automatic int cmp_w(input int data_w, input int para_w);
    return data_w > para_w ? data_w : para_w;
  endfunction
  function automatic int cnt_w(input int depth);
    return depth > 1 ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/rsign_lane.sv
// rsign_lane: one channel's window comparators against its threshold (RSIGN_GE_EN selects >=)
module rsign_lane
  import rsign_pkg::*;
#(
  parameter int CORE_SIZE = 9,
  parameter int DATA_W    = 16,
  parameter int PARA_W    = 16
) (
  input  logic [CORE_SIZE-1:0][DATA_W-1:0] data,
  input  logic [PARA_W-1:0]                thr,
  output logic [CORE_SIZE-1:0]             bits
);
  localparam int W = cmp_w(DATA_W, PARA_W);
  logic signed [W-1:0] t;
  assign t = W'($signed(thr));
  for (genvar j = 0; j < CORE_SIZE; j++) begin : g_cmp
    logic signed [W-1:0] d;
    assign d = W'($signed(data[j]));
`ifdef RSIGN_GE_EN
    assign bits[j] = d >= t;
`else
    assign bits[j] = d > t;
`endif
  end
endmodule

// File: rtl/rsign_stream.sv
// rsign_stream: per-channel threshold binariser with load/run FSM and valid/ready output stage (RSIGN_GE_EN selects >=)
module rsign_stream
  import rsign_pkg::*;
#(
  parameter int FM_DEPTH  = 64,
  parameter int CORE_SIZE = 9,
  parameter int DATA_W    = 16,
  parameter int PARA_W    = 16
) (
  input  logic                                          clk,
  input  logic                                          rstn,
  input  logic                                          mode_in,
  input  logic                                          para_valid,
  input  logic [PARA_W-1:0]                             para_in,
  output logic                                          para_done,
  output logic                                          loaded,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [FM_DEPTH-1:0][CORE_SIZE-1:0][DATA_W-1:0] data_in,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [FM_DEPTH-1:0][CORE_SIZE-1:0]            data_out
);
  localparam int CW = cnt_w(FM_DEPTH);
  localparam logic [CW-1:0] LAST = CW'(FM_DEPTH - 1);
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [FM_DEPTH-1:0][PARA_W-1:0] thr;
  logic [FM_DEPTH-1:0][CORE_SIZE-1:0] bits;
  logic load_we, load_last, load_entry, accept;
  always_comb begin
    state_nx   = mode_in ? S_RUN : S_LOAD;
    load_we    = state == S_LOAD && para_valid;
    load_last  = load_we && cnt == LAST;
    load_entry = state == S_RUN && state_nx == S_LOAD;
    in_ready   = state == S_RUN && loaded && (!out_valid || out_ready);
    accept     = in_valid && in_ready;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= S_LOAD;
      cnt       <= '0;
      loaded    <= 1'b0;
      para_done <= 1'b0;
      thr       <= '0;
    end else begin
      state     <= state_nx;
      para_done <= load_last;
      if (load_entry) begin
        cnt    <= '0;
        loaded <= 1'b0;
      end else if (load_we) begin
        thr[cnt] <= para_in;
        cnt      <= load_last ? '0 : cnt + 1'b1;
        loaded   <= loaded | load_last;
      end
    end
  end
  // a stalled word stays put; a mode drop does not touch the output stage
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      data_out  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      data_out  <= bits;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
  for (genvar i = 0; i < FM_DEPTH; i++) begin : g_lane
    rsign_lane #(.CORE_SIZE(CORE_SIZE), .DATA_W(DATA_W), .PARA_W(PARA_W)) u_lane (
      .data(data_in[i]),
      .thr (thr[i]),
      .bits(bits[i])
    );
  end
endmodule

// File: tb/tb_rsign_stream.sv
// tb_rsign_stream: directed, table-driven and randomized checks of rsign_stream against a behavioural model
module tb_rsign_stream;
  localparam int D = 64, C = 9, DW = 16, PW = 16, N = D * C;
`ifdef RSIGN_GE_EN
  localparam bit GE = 1'b1;
`else
  localparam bit GE = 1'b0;
`endif
  logic clk = 1'b0, rstn = 1'b0;
  always #5 clk = ~clk;
  logic mode_in, para_valid, para_done, loaded, in_valid, in_ready, out_valid, out_ready;
  logic [PW-1:0] para_in;
  logic [D-1:0][C-1:0][DW-1:0] data_in;
  logic [D-1:0][C-1:0] data_out;
  rsign_stream #(.FM_DEPTH(D), .CORE_SIZE(C), .DATA_W(DW), .PARA_W(PW)) dut (
    .clk(clk), .rstn(rstn), .mode_in(mode_in), .para_valid(para_valid), .para_in(para_in),
    .para_done(para_done), .loaded(loaded), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out)
  );
  logic s_mode, s_pv, s_pd, s_loaded, s_iv, s_ir, s_ov, s_or;
  logic [15:0] s_para;
  logic [1:0][0:0][7:0] s_data;
  logic [1:0][0:0] s_dout;
  rsign_stream #(.FM_DEPTH(2), .CORE_SIZE(1), .DATA_W(8), .PARA_W(16)) dut8 (
    .clk(clk), .rstn(rstn), .mode_in(s_mode), .para_valid(s_pv), .para_in(s_para),
    .para_done(s_pd), .loaded(s_loaded), .in_valid(s_iv), .in_ready(s_ir),
    .data_in(s_data), .out_valid(s_ov), .out_ready(s_or), .data_out(s_dout)
  );
  int checks = 0, errors = 0, pd_cnt = 0;
  int thr_m[D];
  int cnt_m;
  bit run_m, loaded_m, ov_m, pd_m;
  logic [D-1:0][C-1:0] dout_m;
  typedef struct {int thr; int data; bit gt; bit ge;} vec_t;
  vec_t tbl[11];
  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b", nm, act, exp);
    end
  endtask
  task automatic chkw(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask
  function automatic bit cmpb(input int d, input int t);
    return GE ? d >= t : d > t;
  endfunction
  function automatic logic [D-1:0][C-1:0] exp_word();
    logic [D-1:0][C-1:0] w;
    for (int i = 0; i < D; i++)
      for (int j = 0; j < C; j++) w[i][j] = cmpb(int'($signed(data_in[i][j])), thr_m[i]);
    return w;
  endfunction
  task automatic model_reset();
    foreach (thr_m[i]) thr_m[i] = 0;
    cnt_m = 0; run_m = 0; loaded_m = 0; ov_m = 0; pd_m = 0; dout_m = '0;
  endtask
  // mode 0: data = i+1, mode 1: data = i, mode 2: random around the modelled threshold
  task automatic set_data(input int mode);
    for (int i = 0; i < D; i++)
      for (int j = 0; j < C; j++)
        data_in[i][j] = DW'(mode == 0 ? i + 1 : mode == 1 ? i : thr_m[i] + int'($urandom_range(0, 2)) - 1);
  endtask
  task automatic tick();
    bit rdy;
    @(negedge clk);
    rdy = run_m && loaded_m && (!ov_m || out_ready);
    chk1("in_ready", in_ready, rdy);
    chk1("out_valid", out_valid, ov_m);
    chk1("para_done", para_done, pd_m);
    chk1("loaded", loaded, loaded_m);
    if (ov_m) chkw("data_out", data_out, dout_m);
    if (para_done) pd_cnt++;
    if (in_valid && rdy) begin
      dout_m = exp_word();
      ov_m = 1;
    end else if (out_ready) ov_m = 0;
    pd_m = 0;
    if (!run_m && para_valid) begin
      thr_m[cnt_m] = int'($signed(para_in));
      pd_m = cnt_m == D - 1;
      loaded_m = loaded_m | pd_m;
      cnt_m = (cnt_m + 1) % D;
    end else if (run_m && !mode_in) begin
      cnt_m = 0;
      loaded_m = 0;
    end
    run_m = mode_in;
    @(posedge clk); #1;
  endtask
  task automatic load(input int n, input int offs, input bit rnd);
    int k = 0;
    while (k < n) begin
      para_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      para_in = PW'(rnd ? int'($urandom_range(0, 16)) - 8 : k + offs);
      if (para_valid) k++;
      tick();
    end
    para_valid = 0;
  endtask
  task automatic step();
    @(posedge clk); #1;
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    tbl[0]  = '{-200, -128, 1, 1};
    tbl[1]  = '{0, 0, 0, 1};
    tbl[2]  = '{-1, -1, 0, 1};
    tbl[3]  = '{127, 127, 0, 1};
    tbl[4]  = '{128, 127, 0, 0};
    tbl[5]  = '{-129, -128, 1, 1};
    tbl[6]  = '{5, -3, 0, 0};
    tbl[7]  = '{-32768, -128, 1, 1};
    tbl[8]  = '{32767, 127, 0, 0};
    tbl[9]  = '{-128, -128, 0, 1};
    tbl[10] = '{-2, 1, 1, 1};
    mode_in = 0; para_valid = 0; para_in = '0; in_valid = 0; out_ready = 0; data_in = '0;
    s_mode = 0; s_pv = 0; s_para = '0; s_iv = 0; s_or = 1; s_data = '0;
    model_reset();
    step(); step();
    chk1("rst_in_ready", in_ready, 1'b0);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_loaded", loaded, 1'b0);
    chk1("rst_para_done", para_done, 1'b0);
    chkw("rst_data_out", data_out, '0);
    rstn = 1;
    mode_in = 1; in_valid = 1; set_data(0);
    repeat (4) tick();
    chk1("noload_out_valid", out_valid, 1'b0);
    mode_in = 0; in_valid = 0;
    tick();
    pd_cnt = 0;
    load(D, 0, 0);
    tick();
    chk1("para_done_once", pd_cnt == 1, 1'b1);
    mode_in = 1; in_valid = 1; out_ready = 1; set_data(0);
    tick(); tick();
    chk1("latency_valid", out_valid, 1'b1);
    chkw("gt_all_ones", data_out, '1);
    set_data(1);
    tick();
    chkw("equal_case", data_out, {N{GE}});
    out_ready = 0;
    for (int k = 0; k < 5; k++) begin
      set_data(2);
      tick();
      chk1("bp_in_ready", in_ready, 1'b0);
    end
    chkw("bp_hold", data_out, {N{GE}});
    out_ready = 1;
    repeat (6) begin set_data(2); tick(); end
    in_valid = 0;
    tick(); tick();
    for (int r = 0; r < 6; r++) begin
      mode_in = 0; in_valid = 0;
      tick();
      load(r == 2 ? 30 : D, 0, 1);
      mode_in = 1;
      repeat (60) begin
        in_valid = $urandom_range(0, 1) != 0;
        out_ready = $urandom_range(0, 3) != 0;
        set_data(2);
        tick();
      end
    end
    mode_in = 0; in_valid = 0; out_ready = 1;
    tick();
    load(10, 0, 1);
    mode_in = 1; in_valid = 1; set_data(0);
    repeat (3) tick();
    chk1("partial_loaded", loaded, 1'b0);
    chk1("partial_ready", in_ready, 1'b0);
    mode_in = 0; in_valid = 0;
    tick();
    load(D, 1, 0);
    mode_in = 1; in_valid = 1; set_data(0);
    tick(); tick();
    chk1("reload_valid", out_valid, 1'b1);
    chkw("reload_thr", data_out, {N{GE}});
    out_ready = 0; set_data(2);
    tick();
    chk1("pre_reset_ov", out_valid, 1'b1);
    rstn = 0;
    #1;
    chk1("async_out_valid", out_valid, 1'b0);
    chkw("async_data_out", data_out, '0);
    chk1("async_loaded", loaded, 1'b0);
    chk1("async_in_ready", in_ready, 1'b0);
    model_reset();
    mode_in = 0; in_valid = 0; out_ready = 1;
    step(); step();
    rstn = 1;
    tick();
    load(D, 0, 1);
    mode_in = 1;
    repeat (40) begin
      in_valid = $urandom_range(0, 1) != 0;
      out_ready = $urandom_range(0, 1) != 0;
      set_data(2);
      tick();
    end
    mode_in = 0; in_valid = 0;
    foreach (tbl[k]) begin
      s_mode = 0; s_pv = 0; s_iv = 0; s_or = 1;
      step();
      s_pv = 1; s_para = 16'(tbl[k].thr);
      step(); step();
      s_pv = 0; s_mode = 1; s_iv = 1;
      s_data[0][0] = 8'(tbl[k].data);
      s_data[1][0] = 8'(tbl[k].data);
      step();
      chk1("t8_early", s_ov, 1'b0);
      step();
      chk1("t8_valid", s_ov, 1'b1);
      chk1("t8_lane0", s_dout[0][0], GE ? tbl[k].ge : tbl[k].gt);
      chk1("t8_lane1", s_dout[1][0], GE ? tbl[k].ge : tbl[k].gt);
      s_iv = 0;
    end
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
